stopwatch_display_mux: RTL
==========================

Name: stopwatch_display_mux

Overview:
- Downstream consumer of the stopwatch counter's minutes/seconds outputs; drives the board's 4-digit common-anode seven-segment display.
- Converts each 6-bit field to two BCD digits and time-multiplexes the digits onto a shared segment bus.
- Blinks the field under adjustment while adjust mode is active.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays lit (must be >= 2).
- BLINK_DIV, 25000000, clock cycles per blink half-period (must be >= 2).

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  reset, asynchronous, active-high.
- minutes  input  6  minutes value from the counter, nominally 0..59.
- seconds  input  6  seconds value from the counter, nominally 0..59.
- adj  input  1  adjust mode active (blink enable).
- sel  input  1  field under adjustment: 0 = minutes, 1 = seconds.
- seg  output  8  cathodes, active-low, {dp,g,f,e,d,c,b,a}.
- an  output  4  anodes, active-low; an[3] is the leftmost digit.

Behaviour:
- Reset (async assert): seg=8'hFF, an=4'hF, refresh_cnt=0, blink_cnt=0, blink_on=1, digit_idx=0, snapshot regs=0. All state is cleared immediately; no mid-scan state survives.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps. tick = (refresh_cnt == REFRESH_DIV-1).
- Digit state machine: states D0..D3, advancing D0->D1->D2->D3->D0 on each tick.
  - D0 = minute tens on an[3].
  - D1 = minute ones on an[2].
  - D2 = second tens on an[1].
  - D3 = second ones on an[0].
- Snapshot: on the tick that moves D3->D0, register minutes/seconds into min_q/sec_q. All four digits of one scan come from the same snapshot, so a rollover cannot tear the display. The first snapshot after reset is taken at the first D3->D0 tick; until then min_q=sec_q=0.
- Outputs are registered. The new an/seg pair appears on the clk edge following the tick.
  - Exactly one an bit is low whenever out of reset.
  - an and seg always change on the same edge.
- BCD conversion: tens = v/10, ones = v%10 for v in 0..59. Any v in 60..63 shows "-" on both digits of that field (seg = 8'hBF, g segment only).
- Segment codes, active-low, dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1; blink_on toggles at the wrap.
  - While adj=0: blink_cnt is held at 0 and blink_on is forced to 1.
  - When adj rises, the first off phase therefore begins BLINK_DIV cycles later.
  - While adj=1 and blink_on=0, the two digits of the selected field output seg=8'hFF; their anode is still driven, preserving scan timing.
  - Unselected digits are never blanked.
  - sel changing mid-phase takes effect on the next registered digit output.
- Simultaneous tick and blink wrap: both take effect on the same edge, and the new digit uses the updated blink_on.

Optional Feature:
- Macro COLON_DP_EN.
- Defined: the dp bit (seg[7]) is driven low (lit) on digit D1, visually separating MM.SS. It is blanked together with the minute digit when that digit is blink-blanked.
- Undefined: seg[7] is 1 on every digit.

Decomposition:
- Package seg7_pkg holds:
  - the digit index type (2-bit enum D0..D3);
  - the segment constants SEG_BLANK=8'hFF and SEG_DASH=8'hBF;
  - the 10-entry digit-to-segment constant table.
- One sub-module, bin60_to_bcd: combinational, 6-bit in, tens[3:0]/ones[3:0]/invalid out. Instantiated twice (minutes, seconds).
- Everything else stays in the top module.

Test Plan (REFRESH_DIV=4, BLINK_DIV=16):
- rst=1 mid-scan with seg showing "3" -> seg=FF and an=F immediately (async). After release, D0 is first driven 4 cycles later, with min_q=0 showing "C0" on an=0111.
- minutes=12, seconds=34, adj=0; run 3 scans -> from the second scan, an sequence 0111,1011,1101,1110 with seg F9,A4,B0,99, 4 cycles each.
- seconds changes 34->35 while in D2 -> current scan still shows 3,4; the next scan shows 3,5.
- minutes=61 -> an[3] and an[2] both show BF; the seconds digits are unaffected.
- adj=1, sel=1, minutes=5, seconds=9 -> seconds digits show C0/90 for 16 cycles, then FF for 16 cycles, alternating; minute digits are steady. Dropping adj mid-off-phase shows the seconds digits on the next digit output.
- COLON_DP_EN defined, minutes=7 -> D1 seg=78 (F8 with dp lit). With adj=1, sel=0, off phase -> D1 seg=FF.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: digit scan index, blank/dash codes and the
// active-low digit glyph table ({dp,g,f,e,d,c,b,a}, dp off).
package seg7_pkg;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } digitIdx_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Entry [n] is the glyph for decimal digit n.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] digitSeg(input logic [3:0] digit);
    logic [7:0] code;
    code = SEG_DASH;
    for (int i = 0; i < 10; i++) begin
      if (digit == 4'(i)) code = SEG_TABLE[i];
    end
    return code;
  endfunction

endpackage

// File: rtl/bin60_to_bcd.sv
// Splits a 6-bit minutes/seconds field into two BCD digits; values above 59
// are flagged invalid so the display can show dashes instead.
module bin60_to_bcd (
  input  logic [5:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       invalid
);

  always_comb begin
    invalid = (value > 6'd59);
    tens    = 4'(value / 6'd10);
    ones    = 4'(value % 6'd10);
  end

endmodule

// File: rtl/stopwatch_display_mux.sv
// Four-digit MM:SS multiplexer for a common-anode seven-segment display with
// adjust-mode blinking. Define COLON_DP_EN to light the dp after the minutes.
module stopwatch_display_mux
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adj,
  input  logic       sel,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [RW-1:0] refreshCnt;
  logic [BW-1:0] blinkCnt;
  logic          blinkOn;
  digitIdx_t     digitIdx;
  logic [5:0]    minQ;
  logic [5:0]    secQ;

  logic       tick;
  logic       blinkWrap;
  logic       blinkOnNext;
  logic [3:0] minTens, minOnes, secTens, secOnes;
  logic       minInvalid, secInvalid;
  logic [3:0] digitVal;
  logic       fieldInvalid;
  logic       isSecField;
  logic       blankDigit;
  logic       dpLit;
  logic [7:0] glyph;
  logic [7:0] segNext;
  logic [3:0] anNext;

  bin60_to_bcd minConv (
    .value   (minQ),
    .tens    (minTens),
    .ones    (minOnes),
    .invalid (minInvalid)
  );

  bin60_to_bcd secConv (
    .value   (secQ),
    .tens    (secTens),
    .ones    (secOnes),
    .invalid (secInvalid)
  );

  assign tick        = (refreshCnt == RW'(REFRESH_DIV - 1));
  assign blinkWrap   = adj && (blinkCnt == BW'(BLINK_DIV - 1));
  // The digit latched on this edge must see the blink phase after this edge.
  assign blinkOnNext = adj ? (blinkOn ^ blinkWrap) : 1'b1;

  always_comb begin
    digitVal     = minTens;
    fieldInvalid = minInvalid;
    isSecField   = 1'b0;
    case (digitIdx)
      D0: begin digitVal = minTens; fieldInvalid = minInvalid; isSecField = 1'b0; end
      D1: begin digitVal = minOnes; fieldInvalid = minInvalid; isSecField = 1'b0; end
      D2: begin digitVal = secTens; fieldInvalid = secInvalid; isSecField = 1'b1; end
      D3: begin digitVal = secOnes; fieldInvalid = secInvalid; isSecField = 1'b1; end
      default: ;
    endcase

`ifdef COLON_DP_EN
    dpLit = (digitIdx == D1);
`else
    dpLit = 1'b0;
`endif

    glyph      = fieldInvalid ? SEG_DASH : digitSeg(digitVal);
    blankDigit = adj && !blinkOnNext && (sel == isSecField);
    segNext    = blankDigit ? SEG_BLANK : {~dpLit, glyph[6:0]};
    anNext     = ~(4'b1000 >> digitIdx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refreshCnt <= '0;
      blinkCnt   <= '0;
      blinkOn    <= 1'b1;
      digitIdx   <= D0;
      minQ       <= '0;
      secQ       <= '0;
      seg        <= SEG_BLANK;
      an         <= 4'hF;
    end else begin
      refreshCnt <= tick ? '0 : refreshCnt + 1'b1;

      if (!adj) begin
        blinkCnt <= '0;
      end else if (blinkWrap) begin
        blinkCnt <= '0;
      end else begin
        blinkCnt <= blinkCnt + 1'b1;
      end
      blinkOn <= blinkOnNext;

      if (tick) begin
        seg      <= segNext;
        an       <= anNext;
        digitIdx <= digitIdx_t'(digitIdx + 2'd1);
        // Snapshot at the end of a scan so one scan never mixes two values.
        if (digitIdx == D3) begin
          minQ <= minutes;
          secQ <= seconds;
        end
      end
    end
  end

endmodule
